fc_irq_bridge: RTL and testbench
================================

Name: fc_irq_bridge

Overview:
- Parametrised interrupt bridge between the FC event/interrupt controller and the FC core. It generalises the fixed 32-line ID-to-one-hot conversion.
- Accepts N_IRQ interrupt lines. Each line is individually configured as edge or level.
- Latches pending interrupts, applies per-line enables, selects by fixed priority and runs a request/acknowledge handshake with the core.
- Presents the selected interrupt in two forms at once: encoded ID (RI5CY-style) and one-hot vector (Ibex irq_x-style).

Parameters:
- N_IRQ, 32, number of interrupt lines (2..64).
- ID_WIDTH, $clog2(N_IRQ), width of the interrupt ID.
- EDGE_MASK, {N_IRQ{1'b0}}, per-line mode: bit=1 means rising-edge triggered, bit=0 means level.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- irq_i  in  N_IRQ  raw interrupt lines, synchronous to clk_i
- irq_en_i  in  N_IRQ  per-line enable mask
- irq_req_o  out  1  interrupt request to core
- irq_id_o  out  ID_WIDTH  ID of the requested interrupt
- irq_x_o  out  N_IRQ  one-hot of irq_id_o while irq_req_o=1, else 0
- irq_ack_i  in  1  core acknowledge, single-cycle pulse
- irq_ack_id_i  in  ID_WIDTH  ID being acknowledged
- pending_o  out  N_IRQ  pending register contents
- overflow_o  out  1  one-cycle pulse: an edge was lost on an already-pending line
- ack_err_o  out  1  one-cycle pulse: ack with a mismatched ID

Behaviour:
- Interface (already decided): one clock, clk_i; reset rst_i is asynchronous and active-high.
- Reset: pending=0, irq_q=0, state=IDLE, id register=0. All outputs are 0 during and after reset until an interrupt is pending.
- Edge lines:
  - irq_q registers irq_i every cycle; edge = irq_i & ~irq_q.
  - An edge sets the pending bit.
  - An ack of that line clears the bit. If an edge and the clearing ack occur in the same cycle, set wins: the bit stays 1 and overflow_o does not pulse.
  - An edge on an already-pending line with no clearing ack that cycle -> overflow_o=1 next cycle.
- Level lines: the pending bit is re-sampled from irq_i every cycle. Ack does not clear it; the source must deassert.
- Candidates = pending & irq_en_i. Priority is fixed: lowest index wins.
- FSM states: IDLE, REQ, GAP.
  - IDLE: if any candidate, register its index into id_q and go to REQ; else stay.
  - REQ: irq_req_o=1, irq_id_o=id_q, held stable. No preemption by higher-priority arrivals.
    - irq_ack_i=1 and irq_ack_id_i==id_q -> clear pending (edge lines only), go to GAP.
    - irq_ack_i=1 and irq_ack_id_i!=id_q -> ack_err_o=1 next cycle, stay in REQ, nothing cleared.
    - No ack and line id_q is no longer a candidate (masked, or level line deasserted) -> withdraw: go to IDLE.
    - If ack and withdraw occur in the same cycle, ack takes priority.
  - GAP: irq_req_o=0 for exactly one cycle, then IDLE.
- irq_req_o = (state==REQ), registered state. irq_id_o=id_q in all states. irq_x_o is qualified by irq_req_o.
- Latency:
  - irq_i rising at cycle t (line enabled, FSM in IDLE) -> pending visible t+1 -> irq_req_o=1 at t+2.
  - Matching ack at cycle t -> irq_req_o=0 at t+1 and t+2 -> next request at t+3 at earliest.
- Enable changes act on the next candidate evaluation. A line that is masked but pending stays pending and does not request.
- Asserting rst_i mid-handshake returns to IDLE immediately (asynchronous) and drops all pending state. The core must not rely on an ack after reset.

Test Plan:
- N_IRQ=32, EDGE_MASK=all edge, all enabled; pulse irq_i[7] for 1 cycle at t -> irq_req_o=1 at t+2, irq_id_o=7, irq_x_o=32'h80; ack id 7 -> pending_o[7]=0, irq_req_o=0 next cycle.
- Edges on lines 3 and 12 in the same cycle -> id 3 served first. After ack: 2-cycle gap, then id 12 requested. After its ack: pending_o=0.
- Line 5 edge while already pending (no ack) -> overflow_o=1 for one cycle. Edge on line 5 in the same cycle as the ack of 5 -> pending_o[5] stays 1, line re-requested 3 cycles after ack, no overflow_o.
- Level line 9 held high, request raised, then irq_en_i[9]=0 before ack -> irq_req_o drops next cycle with no ack_err_o. Re-enable -> request for id 9 again.
- During REQ id 4, ack with id 6 -> ack_err_o pulse, irq_req_o stays 1 with id 4, pending_o[4] still 1.
- Assert rst_i asynchronously while irq_req_o=1 -> all outputs 0 immediately. After release, with no inputs active, outputs stay 0.

Source files
------------

// File: rtl/fc_irq_bridge.sv
// Interrupt bridge: latches edge/level lines, masks, picks the lowest pending ID and handshakes it to the core.
// Latency: irq_i rise at t -> pending at t+1 -> irq_req_o at t+2; matching ack at t -> next request no earlier than t+3.
// Backpressure: a request is held stable until it is acknowledged or withdrawn; further edges on a pending line are counted as overflow.
module fc_irq_bridge #(
    parameter int                 N_IRQ     = 32,
    parameter int                 ID_WIDTH  = $clog2(N_IRQ),
    parameter logic [N_IRQ-1:0]   EDGE_MASK = {N_IRQ{1'b0}}
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [N_IRQ-1:0]      irq_i,
    input  logic [N_IRQ-1:0]      irq_en_i,
    output logic                  irq_req_o,
    output logic [ID_WIDTH-1:0]   irq_id_o,
    output logic [N_IRQ-1:0]      irq_x_o,
    input  logic                  irq_ack_i,
    input  logic [ID_WIDTH-1:0]   irq_ack_id_i,
    output logic [N_IRQ-1:0]      pending_o,
    output logic                  overflow_o,
    output logic                  ack_err_o
);

    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

    state_t                state_q, state_d;
    logic [N_IRQ-1:0]      irq_q;
    logic [N_IRQ-1:0]      pending_q, pending_d;
    logic [N_IRQ-1:0]      edge_det, cand, clr_vec, id_onehot;
    logic [ID_WIDTH-1:0]   id_q, id_d, sel_id;
    logic                  sel_vld, ack_match, ack_mismatch, ovf_d;
    logic                  overflow_q, ack_err_q;

    assign edge_det     = irq_i & ~irq_q & EDGE_MASK;
    assign cand         = pending_q & irq_en_i;
    assign id_onehot    = {{(N_IRQ-1){1'b0}}, 1'b1} << id_q;
    assign ack_match    = (state_q == REQ) && irq_ack_i && (irq_ack_id_i == id_q);
    assign ack_mismatch = (state_q == REQ) && irq_ack_i && (irq_ack_id_i != id_q);
    assign clr_vec      = ack_match ? (id_onehot & EDGE_MASK) : '0;

    // Set beats clear on edge lines; level lines simply mirror the raw input.
    assign pending_d = (EDGE_MASK & ((pending_q & ~clr_vec) | edge_det)) | (~EDGE_MASK & irq_i);
    assign ovf_d     = |(edge_det & pending_q & ~clr_vec);

    always_comb begin
        sel_vld = 1'b0;
        sel_id  = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                sel_vld = 1'b1;
                sel_id  = ID_WIDTH'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    id_d    = sel_id;
                    state_d = REQ;
                end
            end
            REQ: begin
                // A mismatched ack keeps the request alive even if the line was withdrawn.
                if (ack_match)
                    state_d = GAP;
                else if (!irq_ack_i && !cand[id_q])
                    state_d = IDLE;
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            id_q       <= '0;
            irq_q      <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            ack_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            irq_q      <= irq_i;
            pending_q  <= pending_d;
            overflow_q <= ovf_d;
            ack_err_q  <= ack_mismatch;
        end
    end

    assign irq_req_o  = (state_q == REQ);
    assign irq_id_o   = id_q;
    assign irq_x_o    = irq_req_o ? id_onehot : '0;
    assign pending_o  = pending_q;
    assign overflow_o = overflow_q;
    assign ack_err_o  = ack_err_q;

endmodule

// File: tb/tb_fc_irq_bridge.sv
// Bench for fc_irq_bridge: directed handshake scenarios then random traffic, checked every cycle against a cycle model.
module tb_fc_irq_bridge;

    localparam int          N   = 32;
    localparam int          IDW = 5;
    localparam logic [31:0] EM  = ~(32'h0000_0200 | 32'h0030_0000); // lines 9, 20, 21 are level

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    irq = '0;
    logic [N-1:0]    en  = '1;
    logic            ack = 1'b0;
    logic [IDW-1:0]  ack_id = '0;
    logic            irq_req;
    logic [IDW-1:0]  irq_id;
    logic [N-1:0]    irq_x;
    logic [N-1:0]    pending;
    logic            overflow;
    logic            ack_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: mode 0 = idle, 1 = requesting, 2 = gap.
    logic [N-1:0] m_pend, m_prev;
    int           m_mode, m_id;
    logic         m_ovf, m_err;

    fc_irq_bridge #(.N_IRQ(N), .EDGE_MASK(EM)) dut (
        .clk_i(clk), .rst_i(rst), .irq_i(irq), .irq_en_i(en),
        .irq_req_o(irq_req), .irq_id_o(irq_id), .irq_x_o(irq_x),
        .irq_ack_i(ack), .irq_ack_id_i(ack_id),
        .pending_o(pending), .overflow_o(overflow), .ack_err_o(ack_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_prev = '0; m_mode = 0; m_id = 0; m_ovf = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_step();
        logic [N-1:0] np;
        logic         ov, matched, e, cleared;
        int           nmode, nid;
        if (rst) begin
            model_reset();
            return;
        end
        matched = (m_mode == 1) && ack && (int'(ack_id) == m_id);
        ov = 1'b0;
        for (int i = 0; i < N; i++) begin
            e       = EM[i] && irq[i] && !m_prev[i];
            cleared = matched && (i == m_id);
            if (EM[i]) np[i] = e || (m_pend[i] && !cleared);
            else       np[i] = irq[i];
            if (e && m_pend[i] && !cleared) ov = 1'b1;
        end
        nmode = m_mode;
        nid   = m_id;
        if (m_mode == 0) begin
            for (int i = N - 1; i >= 0; i--)
                if (m_pend[i] && en[i]) begin nid = i; nmode = 1; end
        end else if (m_mode == 1) begin
            if (matched) nmode = 2;
            else if (!ack && !(m_pend[m_id] && en[m_id])) nmode = 0;
        end else begin
            nmode = 0;
        end
        m_err  = (m_mode == 1) && ack && (int'(ack_id) != m_id);
        m_ovf  = ov;
        m_pend = np;
        m_prev = irq;
        m_mode = nmode;
        m_id   = nid;
    endtask

    task automatic compare_all();
        logic [N-1:0] ex;
        ex = (m_mode == 1) ? (32'h1 << m_id) : 32'h0;
        check("req",      irq_req, m_mode == 1);
        check("id",       irq_id, m_id);
        check("x",        irq_x, ex);
        check("pending",  pending, m_pend);
        check("overflow", overflow, m_ovf);
        check("ack_err",  ack_err, m_err);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse(input int line);
        irq[line] = 1'b1;
        tick();
        irq[line] = 1'b0;
    endtask

    task automatic do_ack(input int id);
        ack = 1'b1; ack_id = IDW'(id);
        tick();
        ack = 1'b0;
    endtask

    initial begin
        model_reset();
        #12;
        check("rst_req", irq_req, 1'b0);
        check("rst_x", irq_x, 32'h0);
        check("rst_pend", pending, 32'h0);
        check("rst_id", irq_id, 5'd0);
        @(negedge clk);
        rst = 1'b0;
        ticks(2);

        // Single edge on line 7
        pulse(7);
        tick();
        check("l7_req", irq_req, 1'b1);
        check("l7_id", irq_id, 5'd7);
        check("l7_x", irq_x, 32'h80);
        do_ack(7);
        check("l7_clr", pending[7], 1'b0);
        check("l7_drop", irq_req, 1'b0);
        ticks(2);

        // Simultaneous edges: 3 wins, 12 follows after a 2-cycle gap
        irq[3] = 1'b1; irq[12] = 1'b1;
        tick();
        irq = '0;
        tick();
        check("p_id3", irq_id, 5'd3);
        do_ack(3);
        check("p_gap1", irq_req, 1'b0);
        tick();
        check("p_gap2", irq_req, 1'b0);
        tick();
        check("p_req12", irq_req, 1'b1);
        check("p_id12", irq_id, 5'd12);
        do_ack(12);
        check("p_empty", pending, 32'h0);
        ticks(2);

        // Overflow on line 5, then edge colliding with its ack
        pulse(5);
        tick();
        irq[5] = 1'b1;
        tick();
        check("ovf_pulse", overflow, 1'b1);
        irq[5] = 1'b0;
        tick();
        check("ovf_once", overflow, 1'b0);
        irq[5] = 1'b1; ack = 1'b1; ack_id = 5'd5;
        tick();
        irq[5] = 1'b0; ack = 1'b0;
        check("coll_pend", pending[5], 1'b1);
        check("coll_noovf", overflow, 1'b0);
        tick();
        check("coll_gap", irq_req, 1'b0);
        tick();
        check("coll_rereq", irq_req, 1'b1);
        check("coll_id", irq_id, 5'd5);
        do_ack(5);
        ticks(2);

        // Mismatched ack
        pulse(4);
        tick();
        do_ack(6);
        check("err_pulse", ack_err, 1'b1);
        check("err_hold", irq_req, 1'b1);
        check("err_id", irq_id, 5'd4);
        check("err_pend", pending[4], 1'b1);
        tick();
        check("err_once", ack_err, 1'b0);
        do_ack(4);
        ticks(2);

        // Level line 9 withdrawn by masking, then re-requested
        irq[9] = 1'b1;
        ticks(2);
        check("lvl_req", irq_req, 1'b1);
        check("lvl_id", irq_id, 5'd9);
        en[9] = 1'b0;
        tick();
        check("lvl_wd", irq_req, 1'b0);
        check("lvl_noerr", ack_err, 1'b0);
        en[9] = 1'b1;
        tick();
        check("lvl_rereq", irq_req, 1'b1);
        check("lvl_reid", irq_id, 5'd9);

        // Asynchronous reset mid-handshake
        #2;
        rst = 1'b1;
        irq = '0;
        model_reset();
        #1;
        check("arst_req", irq_req, 1'b0);
        check("arst_x", irq_x, 32'h0);
        check("arst_pend", pending, 32'h0);
        check("arst_id", irq_id, 5'd0);
        tick();
        @(negedge clk);
        rst = 1'b0;
        ticks(4);
        check("post_rst", {irq_req, irq_x, pending, overflow, ack_err}, 64'h0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            irq = irq ^ ($urandom & $urandom & $urandom);
            if ($urandom_range(0, 15) == 0) en = en ^ (32'h1 << $urandom_range(0, 31));
            if (m_mode == 1 && $urandom_range(0, 3) == 0) begin
                ack    = 1'b1;
                ack_id = ($urandom_range(0, 7) == 0) ? IDW'($urandom_range(0, 31)) : IDW'(m_id);
            end else begin
                ack    = ($urandom_range(0, 31) == 0);
                ack_id = IDW'($urandom_range(0, 31));
            end
            tick();
        end
        ack = 1'b0;
        ticks(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
